scan_mux: RTL and testbench

- Parameterised, registered N-channel, WIDTH-bit multiplexer with a valid/ready output stage.
- Two modes:
  - Manual: a sel-addressed pass-through.
  - Scan: autonomous round-robin sampling of the enabled channels, one sample every DWELL clocks.
- Sits between grouped data sources and a single downstream consumer that may stall.
- Supersedes the fixed 8:1 single-bit combinational mux in new designs.

---
 rtl/scan_mux.sv | 152 +++++++++++++++
 tb/tb_scan_mux.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/scan_mux.sv
// scan_mux: registered N-channel, WIDTH-bit multiplexer with a valid/ready
// output stage. Manual mode passes the sel-addressed channel through with one
// clock of latency; scan mode autonomously visits the enabled channels in
// round-robin order, emitting one sample every DWELL clocks.
//
// State table
//   state  | meaning
//   MANUAL | sel-addressed capture whenever the output slot is free
//   SCAN   | dwell counting, then round-robin emission from ptr
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   din        flattened channel data, channel k at [k*WIDTH +: WIDTH]
//   sel        manual-mode select / scan-mode starting pointer
//   mode       0 = manual, 1 = scan
//   ch_en      per-channel enable mask
//   out_data   registered sample
//   out_ch     channel index that produced out_data
//   out_valid  out_data/out_ch valid
//   out_ready  downstream accepts
module scan_mux #(
    parameter int N     = 8,
    parameter int WIDTH = 8,
    parameter int DWELL = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N*WIDTH-1:0]       din,
    input  logic [$clog2(N)-1:0]     sel,
    input  logic                     mode,
    input  logic [N-1:0]             ch_en,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(N)-1:0]     out_ch,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int SW = $clog2(N);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);
    localparam logic [SW-1:0] LAST_CH = SW'(N - 1);

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [SW-1:0]    ptr, ptr_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] data_nx;
    logic [SW-1:0]    ch_nx;
    logic             valid_nx;

    logic             slot_free;
    logic             found;
    logic [SW-1:0]    hit;
    logic [SW:0]      sum;
    logic [SW-1:0]    idx;
    logic [WIDTH-1:0] ch_data [N];

    assign slot_free = !out_valid || out_ready;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            ch_data[k] = din[k*WIDTH +: WIDTH];
        end
    end

    // Cyclic first-enabled search starting at ptr (inclusive). The sum is one
    // bit wider so ptr + i never overflows before the wrap subtraction.
    always_comb begin
        found = 1'b0;
        hit   = ptr;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (SW+1)'(i);
            if (sum >= (SW+1)'(N)) begin
                sum = sum - (SW+1)'(N);
            end
            idx = sum[SW-1:0];
            if (!found && ch_en[idx]) begin
                found = 1'b1;
                hit   = idx;
            end
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        data_nx  = out_data;
        ch_nx    = out_ch;
        // An accepted sample drops valid unless a new one replaces it below.
        valid_nx = out_valid && !out_ready;

        case (state)
            MANUAL: begin
                if (mode) begin
                    state_nx = SCAN;
                    ptr_nx   = sel;
                    cnt_nx   = '0;
                end else if (slot_free) begin
                    data_nx  = ch_data[sel];
                    ch_nx    = sel;
                    valid_nx = ch_en[sel];
                end
            end
            SCAN: begin
                if (!mode) begin
                    state_nx = MANUAL;
                    cnt_nx   = '0;
                end else if (cnt < CNT_MAX) begin
                    cnt_nx = cnt + CW'(1);
                end else if (slot_free && found) begin
                    data_nx  = ch_data[hit];
                    ch_nx    = hit;
                    valid_nx = 1'b1;
                    ptr_nx   = (hit == LAST_CH) ? '0 : hit + SW'(1);
                    cnt_nx   = '0;
                end
                // Otherwise cnt stays saturated: stalled or empty mask defers
                // the emission without advancing ptr.
            end
            default: begin
                state_nx = MANUAL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MANUAL;
            ptr       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            cnt       <= cnt_nx;
            out_data  <= data_nx;
            out_ch    <= ch_nx;
            out_valid <= valid_nx;
        end
    end

endmodule

// File: tb/tb_scan_mux.sv
// Testbench for scan_mux: two instances (8ch x 4b, dwell 3) and
// (3ch x 1b, dwell 1). Expected samples are queued when stimulus is applied
// and popped by negedge monitors on every valid/ready transfer; cycle timing
// is checked directly after each edge.
module tb_scan_mux;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // instance A
    logic [31:0] din_a;
    logic [2:0]  sel_a;
    logic        mode_a;
    logic [7:0]  ch_en_a;
    logic [3:0]  out_data_a;
    logic [2:0]  out_ch_a;
    logic        out_valid_a;
    logic        out_ready_a;

    // instance B
    logic [2:0]  din_b;
    logic [1:0]  sel_b;
    logic        mode_b;
    logic [2:0]  ch_en_b;
    logic [0:0]  out_data_b;
    logic [1:0]  out_ch_b;
    logic        out_valid_b;
    logic        out_ready_b;

    scan_mux #(.N(8), .WIDTH(4), .DWELL(3)) dut_a (
        .clk(clk), .rst(rst), .din(din_a), .sel(sel_a), .mode(mode_a),
        .ch_en(ch_en_a), .out_data(out_data_a), .out_ch(out_ch_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a)
    );

    scan_mux #(.N(3), .WIDTH(1), .DWELL(1)) dut_b (
        .clk(clk), .rst(rst), .din(din_b), .sel(sel_b), .mode(mode_b),
        .ch_en(ch_en_b), .out_data(out_data_b), .out_ch(out_ch_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] sb_a [$];
    logic [2:0] sb_b [$];
    logic [6:0] e_a;
    logic [2:0] e_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] val_a(input int k);
        return 4'(k + 5);
    endfunction

    task automatic push_a(input int ch);
        sb_a.push_back({3'(ch), val_a(ch)});
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid_a && out_ready_a) begin
            if (sb_a.size() == 0) begin
                check("a_xfer_unexpected", sb_a.size(), 1);
            end else begin
                e_a = sb_a.pop_front();
                check("a_xfer_ch", out_ch_a, e_a[6:4]);
                check("a_xfer_data", out_data_a, e_a[3:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid_b && out_ready_b) begin
            if (sb_b.size() == 0) begin
                check("b_xfer_unexpected", sb_b.size(), 1);
            end else begin
                e_b = sb_b.pop_front();
                check("b_xfer_ch", out_ch_b, e_b[2:1]);
                check("b_xfer_data", out_data_b, e_b[0]);
            end
        end
    end

    int exp_scan [5] = '{0, 2, 5, 7, 0};
    int exp_b_ch [4] = '{0, 1, 2, 0};
    int exp_b_d  [4] = '{1, 0, 1, 1};

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 8; k++) din_a[k*4 +: 4] = val_a(k);
        sel_a = 3'd0; mode_a = 1'b0; ch_en_a = 8'hFF; out_ready_a = 1'b1;
        din_b = 3'b101; sel_b = 2'd0; mode_b = 1'b0; ch_en_b = 3'b000; out_ready_b = 1'b1;

        // power-on reset
        tick();
        check("rst0_valid", out_valid_a, 0);
        check("rst0_data", out_data_a, 0);
        check("rst0_ch", out_ch_a, 0);
        tick();

        // manual capture
        rst = 1'b0; sel_a = 3'd5;
        push_a(5);
        tick();
        check("man_valid", out_valid_a, 1);
        check("man_ch", out_ch_a, 5);
        check("man_data", out_data_a, 4'hA);
        sel_a = 3'd3; ch_en_a = 8'hF7;
        tick();
        check("man_dis_valid", out_valid_a, 0);
        check("man_dis_ch", out_ch_a, 3);

        // scan order
        mode_a = 1'b1; sel_a = 3'd0; ch_en_a = 8'hA5;
        for (int i = 0; i < 5; i++) push_a(exp_scan[i]);
        tick();
        check("scan_entry_valid", out_valid_a, 0);
        for (int j = 1; j <= 15; j++) begin
            tick();
            check($sformatf("scan_valid_%0d", j), out_valid_a, (j % 3 == 0) ? 1 : 0);
            if (j % 3 == 0) begin
                check($sformatf("scan_ch_%0d", j), out_ch_a, exp_scan[j/3 - 1]);
                check($sformatf("scan_data_%0d", j), out_data_a, val_a(exp_scan[j/3 - 1]));
            end
        end

        // leave scan with a disabled sel so manual captures nothing, re-enter
        mode_a = 1'b0; sel_a = 3'd1;
        tick();
        check("exit_valid", out_valid_a, 0);
        mode_a = 1'b1; sel_a = 3'd0;
        push_a(0); push_a(2); push_a(5);
        tick();

        // backpressure: ready low on edges E+2..E+8
        for (int j = 1; j <= 12; j++) begin
            out_ready_a = !(j >= 2 && j <= 8);
            tick();
            if (j <= 2 || j == 10 || j == 11) begin
                check($sformatf("bp_valid_%0d", j), out_valid_a, 0);
            end else if (j <= 8) begin
                check($sformatf("bp_hold_valid_%0d", j), out_valid_a, 1);
                check($sformatf("bp_hold_ch_%0d", j), out_ch_a, 0);
                check($sformatf("bp_hold_data_%0d", j), out_data_a, val_a(0));
            end else begin
                check($sformatf("bp_valid_%0d", j), out_valid_a, 1);
                check($sformatf("bp_ch_%0d", j), out_ch_a, (j == 9) ? 2 : 5);
            end
        end

        // empty mask: nothing emitted, counter saturates
        ch_en_a = 8'h00;
        for (int j = 0; j < 10; j++) begin
            tick();
            check($sformatf("empty_valid_%0d", j), out_valid_a, 0);
        end
        ch_en_a = 8'h01;
        push_a(0);
        tick();
        check("restore_valid", out_valid_a, 1);
        check("restore_ch", out_ch_a, 0);
        check("restore_data", out_data_a, val_a(0));

        // reset during a stalled scan
        out_ready_a = 1'b0;
        tick();
        check("stall_valid", out_valid_a, 1);
        sb_a.delete();
        rst = 1'b1;
        tick();
        check("rst_valid", out_valid_a, 0);
        check("rst_data", out_data_a, 0);
        check("rst_ch", out_ch_a, 0);
        tick();
        rst = 1'b0; mode_a = 1'b0; sel_a = 3'd2; ch_en_a = 8'hFF; out_ready_a = 1'b1;
        push_a(2);
        tick();
        check("post_rst_valid", out_valid_a, 1);
        check("post_rst_ch", out_ch_a, 2);
        check("post_rst_data", out_data_a, val_a(2));
        ch_en_a = 8'h00;
        tick();

        // N=3, WIDTH=1, DWELL=1 sweep with ptr wrap
        mode_b = 1'b1; sel_b = 2'd0; ch_en_b = 3'b111;
        for (int i = 0; i < 4; i++) sb_b.push_back({2'(exp_b_ch[i]), 1'(exp_b_d[i])});
        tick();
        check("b_entry_valid", out_valid_b, 0);
        for (int j = 0; j < 4; j++) begin
            tick();
            check($sformatf("b_valid_%0d", j), out_valid_b, 1);
            check($sformatf("b_ch_%0d", j), out_ch_b, exp_b_ch[j]);
            check($sformatf("b_data_%0d", j), out_data_b, exp_b_d[j]);
        end
        mode_b = 1'b0; ch_en_b = 3'b000;
        tick();
        check("b_exit_valid", out_valid_b, 0);
        tick();

        check("a_sb_drained", sb_a.size(), 0);
        check("b_sb_drained", sb_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
